// File: rtl/fifo_arb_pkg.sv
// Shared types, constants and round-robin helpers for the FIFO write arbiter.
package fifo_arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } arb_state_e;

   localparam int TAG_CDR = 0;
   localparam int MAX_SRC = 4;
   localparam int IDX_W   = 2;
   localparam int BEAT_W  = 8;

   typedef struct packed {
      arb_state_e       state;
      logic [IDX_W-1:0] owner;
      logic [IDX_W-1:0] rr_ptr;
      logic [BEAT_W-1:0] beat;
   } arb_dbg_t;

   // Successor of a handshaked source index, wrapping from the top back to 1.
   function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] cur,
                                                input int num_src);
      if (int'(cur) + 1 >= num_src) return IDX_W'(1);
      return cur + IDX_W'(1);
   endfunction

   function automatic logic [MAX_SRC-1:0] rr_search(input logic [MAX_SRC-1:0] valid,
                                                    input logic [IDX_W-1:0] ptr,
                                                    input int num_src);
      logic [MAX_SRC-1:0] grant;
      logic [IDX_W-1:0]   idx;
      grant = '0;
      idx   = ptr;
      for (int k = 0; k < MAX_SRC - 1; k++) begin
         if (k < num_src - 1 && grant == '0 && valid[idx]) grant[idx] = 1'b1;
         idx = rr_next(idx, num_src);
      end
      return grant;
   endfunction

endpackage

// File: rtl/fifo_arb_rr_pick.sv
// Combinational round-robin picker over sources 1..NUM_SRC-1; one-hot grant.
module fifo_arb_rr_pick
   import fifo_arb_pkg::*;
#(
   parameter int NUM_SRC = 3
) (
   input  logic [NUM_SRC-1:0] valid,
   input  logic [IDX_W-1:0]   rr_ptr,
   output logic [NUM_SRC-1:0] grant
);

   logic [MAX_SRC-1:0] valid_ext;
   logic [MAX_SRC-1:0] grant_ext;
   logic               unused_bits;

   always_comb begin
      valid_ext = '0;
      valid_ext[NUM_SRC-1:1] = valid[NUM_SRC-1:1];
      grant_ext = rr_search(valid_ext, rr_ptr, NUM_SRC);
      grant = grant_ext[NUM_SRC-1:0];
   end

   // Source 0 never takes part in the round robin.
   assign unused_bits = ^{valid[0], grant_ext};

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Write-port arbiter for the CDR async FIFO: src0 absolute priority, others round robin
// with burst locking. Define FIFO_ARB_DROP_CNT_EN to build the dropped-word counter.
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int NUM_SRC    = 3,
   parameter int DATA_WIDTH = 32,
   parameter int TAG_W      = 2,
   parameter int MAX_BURST  = 8,
   parameter int CNT_W      = 16
) (
   input  logic                          clk_wr,
   input  logic                          rst_wr_n,
   input  logic [NUM_SRC-1:0]            req_valid,
   input  logic [NUM_SRC*DATA_WIDTH-1:0] req_data,
   input  logic [NUM_SRC-1:0]            req_last,
   output logic [NUM_SRC-1:0]            req_ready,
   output logic [TAG_W+DATA_WIDTH-1:0]   fifo_din,
   output logic                          fifo_wr_en,
   input  logic                          fifo_full,
   input  logic                          fifo_almost_full,
   input  logic                          clr_stats,
   output logic                          overflow,
   output logic [CNT_W-1:0]              drop_count,
   output arb_dbg_t                      dbg
);

   arb_state_e            state;
   logic [IDX_W-1:0]      owner;
   logic [IDX_W-1:0]      rr_ptr;
   logic [BEAT_W-1:0]     beat;
   logic                  rst_done;
   logic [NUM_SRC-1:0]    pick;
   logic [NUM_SRC-1:0]    ready;
   logic [NUM_SRC-1:0]    xfer;
   logic                  others_ok;
   logic                  acc0;
   logic                  drop0;
   logic                  acc_other;
   logic                  sel_last;
   logic [IDX_W-1:0]      sel_idx;
   logic [DATA_WIDTH-1:0] sel_data;
   logic                  unused_last0;

   assign unused_last0 = req_last[0];

   fifo_arb_rr_pick #(.NUM_SRC(NUM_SRC)) u_pick (
      .valid  (req_valid),
      .rr_ptr (rr_ptr),
      .grant  (pick)
   );

   // A word moves when req_valid[i] & req_ready[i] at a clk_wr edge. Ready never
   // depends on the requester's own data; bit 0 stays high, so a src0 word under
   // fifo_full is consumed and counted as dropped rather than stalled.
   always_comb begin
      others_ok = rst_done & ~req_valid[0] & ~fifo_almost_full & ~fifo_full;
      ready     = '0;
      ready[0]  = rst_done;
      for (int i = 1; i < NUM_SRC; i++) begin
         if (state == BURST) ready[i] = others_ok & (owner == IDX_W'(i));
         else                ready[i] = others_ok & pick[i];
      end
      xfer  = req_valid & ready;
      acc0  = xfer[0] & ~fifo_full;
      drop0 = xfer[0] & fifo_full;

      acc_other = 1'b0;
      sel_idx   = IDX_W'(TAG_CDR);
      sel_data  = req_data[DATA_WIDTH-1:0];
      sel_last  = 1'b0;
      for (int i = 1; i < NUM_SRC; i++) begin
         if (xfer[i]) begin
            acc_other = 1'b1;
            sel_idx   = IDX_W'(i);
            sel_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            sel_last  = req_last[i];
         end
      end
   end

   assign req_ready = ready;

   always_ff @(posedge clk_wr or negedge rst_wr_n) begin
      if (!rst_wr_n) rst_done <= 1'b0;
      else           rst_done <= 1'b1;
   end

   always_ff @(posedge clk_wr or negedge rst_wr_n) begin
      if (!rst_wr_n) begin
         fifo_wr_en <= 1'b0;
         fifo_din   <= '0;
      end else begin
         fifo_wr_en <= acc0 | acc_other;
         if (acc0 | acc_other) fifo_din <= {TAG_W'(sel_idx), sel_data};
      end
   end

   // Burst lock: src0 words slip through without touching owner or beat.
   always_ff @(posedge clk_wr or negedge rst_wr_n) begin
      if (!rst_wr_n) begin
         state  <= IDLE;
         owner  <= '0;
         rr_ptr <= IDX_W'(1);
         beat   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (acc_other) begin
                  if (sel_last || MAX_BURST == 1) begin
                     rr_ptr <= rr_next(sel_idx, NUM_SRC);
                  end else begin
                     state <= BURST;
                     owner <= sel_idx;
                     beat  <= BEAT_W'(1);
                  end
               end
            end
            BURST: begin
               if (acc_other) begin
                  if (sel_last || int'(beat) + 1 >= MAX_BURST) begin
                     state  <= IDLE;
                     rr_ptr <= rr_next(owner, NUM_SRC);
                     beat   <= '0;
                  end else begin
                     beat <= beat + BEAT_W'(1);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_wr or negedge rst_wr_n) begin
      if (!rst_wr_n)      overflow <= 1'b0;
      else if (clr_stats) overflow <= 1'b0;
      else if (drop0)     overflow <= 1'b1;
   end

`ifdef FIFO_ARB_DROP_CNT_EN
   logic [CNT_W-1:0] drop_cnt_q;

   always_ff @(posedge clk_wr or negedge rst_wr_n) begin
      if (!rst_wr_n)                    drop_cnt_q <= '0;
      else if (clr_stats)               drop_cnt_q <= '0;
      else if (drop0 && !(&drop_cnt_q)) drop_cnt_q <= drop_cnt_q + CNT_W'(1);
   end

   assign drop_count = drop_cnt_q;
`else
   assign drop_count = '0;
`endif

   always_comb begin
      dbg.state  = state;
      dbg.owner  = owner;
      dbg.rr_ptr = rr_ptr;
      dbg.beat   = beat;
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: priority, round robin, burst lock, backpressure, reset.
module tb_fifo_wr_arbiter;
   import fifo_arb_pkg::*;

   localparam int NS = 3;
   localparam int DW = 32;
   localparam int TW = 2;
   localparam int MB = 8;
   localparam int CW = 16;
`ifdef FIFO_ARB_DROP_CNT_EN
   localparam int CNT_ON = 1;
`else
   localparam int CNT_ON = 0;
`endif

   logic             clk;
   logic             rst_wr_n;
   logic [NS-1:0]    req_valid;
   logic [NS*DW-1:0] req_data;
   logic [NS-1:0]    req_last;
   logic [NS-1:0]    req_ready;
   logic [TW+DW-1:0] fifo_din;
   logic             fifo_wr_en;
   logic             fifo_full;
   logic             fifo_almost_full;
   logic             clr_stats;
   logic             overflow;
   logic [CW-1:0]    drop_count;
   arb_dbg_t         dbg;

   int               n_vec;
   int               n_err;
   int               seq [NS];
   int               rem [NS];
   int               len [NS];
   logic [TW+DW-1:0] exp_q [$];
   logic [TW+DW-1:0] exp_w;

   fifo_wr_arbiter #(
      .NUM_SRC(NS), .DATA_WIDTH(DW), .TAG_W(TW), .MAX_BURST(MB), .CNT_W(CW)
   ) dut (
      .clk_wr           (clk),
      .rst_wr_n         (rst_wr_n),
      .req_valid        (req_valid),
      .req_data         (req_data),
      .req_last         (req_last),
      .req_ready        (req_ready),
      .fifo_din         (fifo_din),
      .fifo_wr_en       (fifo_wr_en),
      .fifo_full        (fifo_full),
      .fifo_almost_full (fifo_almost_full),
      .clr_stats        (clr_stats),
      .overflow         (overflow),
      .drop_count       (drop_count),
      .dbg              (dbg)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   function automatic logic [DW-1:0] word_data(input int i, input int n);
      return {8'(i), 24'(n)};
   endfunction

   function automatic logic [TW+DW-1:0] exp_word(input int i, input int n);
      return {TW'(i), word_data(i, n)};
   endfunction

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_vec++;
      assert (got === want) else begin
         n_err++;
         $error("FAIL %s: got %0h want %0h", tag, got, want);
      end
   endtask

   task automatic src_apply();
      for (int i = 1; i < NS; i++) begin
         req_valid[i] = (rem[i] != 0);
         req_data[i*DW +: DW] = word_data(i, seq[i]);
         req_last[i] = ((seq[i] % len[i]) == len[i] - 1);
      end
   endtask

   // One clock: check ready mid-cycle, then advance any source whose word moved.
   task automatic cycle(input logic [NS-1:0] exp_ready);
      logic [NS-1:0] hs;
      @(negedge clk);
      chk("ready", 64'(req_ready), 64'(exp_ready));
      hs = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int i = 1; i < NS; i++) begin
         if (hs[i]) begin
            seq[i]++;
            if (rem[i] > 0) rem[i]--;
         end
      end
      req_valid[0] = 1'b0;
      src_apply();
   endtask

   task automatic push0(input int n);
      req_valid[0] = 1'b1;
      req_data[DW-1:0] = word_data(0, n);
   endtask

   task automatic check_reset_vals(input string p);
      chk({p, "_wr_en"},  64'(fifo_wr_en), 64'(0));
      chk({p, "_din"},    64'(fifo_din), 64'(0));
      chk({p, "_ready"},  64'(req_ready), 64'(0));
      chk({p, "_ovf"},    64'(overflow), 64'(0));
      chk({p, "_drops"},  64'(drop_count), 64'(0));
      chk({p, "_state"},  64'(dbg.state), 64'(IDLE));
      chk({p, "_rr_ptr"}, 64'(dbg.rr_ptr), 64'(1));
      chk({p, "_beat"},   64'(dbg.beat), 64'(0));
   endtask

   // Scoreboard: every FIFO write must match the head of the expected queue.
   always @(negedge clk) begin
      if (rst_wr_n && fifo_wr_en) begin
         n_vec++;
         assert (exp_q.size() != 0) else begin
            n_err++;
            $error("FAIL wr_extra: got %h want no write", fifo_din);
         end
         if (exp_q.size() != 0) begin
            exp_w = exp_q.pop_front();
            assert (fifo_din === exp_w) else begin
               n_err++;
               $error("FAIL wr_word: got %h want %h", fifo_din, exp_w);
            end
         end
      end
   end

   initial begin
      n_vec = 0;
      n_err = 0;
      rst_wr_n = 1'b1;
      req_valid = '0;
      req_data = '0;
      req_last = '0;
      fifo_full = 1'b0;
      fifo_almost_full = 1'b0;
      clr_stats = 1'b0;
      for (int i = 0; i < NS; i++) begin
         seq[i] = 0;
         rem[i] = 0;
         len[i] = 1;
      end

      // Reset
      #1 rst_wr_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_vals("rst");
      @(posedge clk);
      #1 rst_wr_n = 1'b1;
      cycle(3'b000);
      cycle(3'b001);

      // CDR priority: 20 src0 words while src1 waits
      rem[1] = -1;
      src_apply();
      for (int k = 0; k < 20; k++) begin
         push0(k);
         exp_q.push_back(exp_word(0, k));
         cycle(3'b001);
      end
      exp_q.push_back(exp_word(1, 0));
      cycle(3'b011);
      exp_q.push_back(exp_word(1, 1));
      cycle(3'b011);
      rem[1] = 0;
      src_apply();
      cycle(3'b001);
      chk("t1_rr_ptr", 64'(dbg.rr_ptr), 64'(2));

      // Round robin with single-word bursts, pointer starting at 2
      rem[1] = -1;
      rem[2] = -1;
      src_apply();
      for (int r = 0; r < 3; r++) begin
         exp_q.push_back(exp_word(2, r));
         cycle(3'b101);
         exp_q.push_back(exp_word(1, 2 + r));
         cycle(3'b011);
      end
      rem[1] = 0;
      rem[2] = 0;
      src_apply();
      cycle(3'b001);
      chk("t2_rr_ptr", 64'(dbg.rr_ptr), 64'(2));

      // Burst lock: 12-word src1 burst cut at 8, src2 slips in, src0 preempts
      seq[1] = 24;
      len[1] = 12;
      rem[1] = 12;
      src_apply();
      exp_q.push_back(exp_word(1, 24));
      cycle(3'b011);
      rem[2] = -1;
      src_apply();
      chk("t3_state", 64'(dbg.state), 64'(BURST));
      chk("t3_owner", 64'(dbg.owner), 64'(1));
      chk("t3_beat1", 64'(dbg.beat), 64'(1));
      for (int k = 1; k < 8; k++) begin
         exp_q.push_back(exp_word(1, 24 + k));
         cycle(3'b011);
      end
      chk("t3_cut_state", 64'(dbg.state), 64'(IDLE));
      chk("t3_cut_ptr", 64'(dbg.rr_ptr), 64'(2));
      exp_q.push_back(exp_word(2, 3));
      cycle(3'b101);
      exp_q.push_back(exp_word(1, 32));
      cycle(3'b011);
      exp_q.push_back(exp_word(1, 33));
      cycle(3'b011);
      chk("t4_beat_pre", 64'(dbg.beat), 64'(2));
      push0(100);
      exp_q.push_back(exp_word(0, 100));
      cycle(3'b001);
      chk("t4_beat_post", 64'(dbg.beat), 64'(2));
      chk("t4_state", 64'(dbg.state), 64'(BURST));
      chk("t4_owner", 64'(dbg.owner), 64'(1));
      exp_q.push_back(exp_word(1, 34));
      cycle(3'b011);
      exp_q.push_back(exp_word(1, 35));
      cycle(3'b011);
      chk("t4_end_state", 64'(dbg.state), 64'(IDLE));
      exp_q.push_back(exp_word(2, 4));
      cycle(3'b101);
      rem[2] = 0;
      src_apply();
      cycle(3'b001);

      // Backpressure: almost-full blocks src1, full drops src0
      seq[1] = 36;
      len[1] = 1;
      rem[1] = -1;
      src_apply();
      fifo_almost_full = 1'b1;
      for (int k = 0; k < 2; k++) begin
         push0(200 + k);
         exp_q.push_back(exp_word(0, 200 + k));
         cycle(3'b001);
      end
      cycle(3'b001);
      fifo_full = 1'b1;
      for (int k = 0; k < 5; k++) begin
         push0(300 + k);
         cycle(3'b001);
         if (k == 0) begin
            chk("t5_ovf1", 64'(overflow), 64'(1));
            chk("t5_drops1", 64'(drop_count), 64'(CNT_ON));
         end
      end
      chk("t5_ovf5", 64'(overflow), 64'(1));
      chk("t5_drops5", 64'(drop_count), 64'(CNT_ON * 5));
      cycle(3'b001);
      chk("t5_ovf_sticky", 64'(overflow), 64'(1));
      clr_stats = 1'b1;
      push0(400);
      cycle(3'b001);
      clr_stats = 1'b0;
      chk("t5_clr_ovf", 64'(overflow), 64'(0));
      chk("t5_clr_drops", 64'(drop_count), 64'(0));
      cycle(3'b001);
      chk("t5_clr_hold", 64'(drop_count), 64'(0));
      fifo_full = 1'b0;
      fifo_almost_full = 1'b0;
      exp_q.push_back(exp_word(1, 36));
      cycle(3'b011);
      rem[1] = 0;
      src_apply();
      cycle(3'b001);

      // Async reset in the middle of a src1 burst
      seq[1] = 40;
      len[1] = 12;
      rem[1] = -1;
      src_apply();
      exp_q.push_back(exp_word(1, 40));
      cycle(3'b011);
      cycle(3'b011);
      chk("t6_inflight", 64'(fifo_wr_en), 64'(1));
      chk("t6_beat", 64'(dbg.beat), 64'(2));
      #1 rst_wr_n = 1'b0;
      #1 check_reset_vals("mid");
      seq[1] = 50;
      len[1] = 1;
      rem[2] = -1;
      src_apply();
      @(posedge clk);
      #1 rst_wr_n = 1'b1;
      cycle(3'b000);
      exp_q.push_back(exp_word(1, 50));
      cycle(3'b011);
      exp_q.push_back(exp_word(2, 5));
      cycle(3'b101);
      rem[1] = 0;
      rem[2] = 0;
      src_apply();
      cycle(3'b001);
      cycle(3'b001);
      chk("queue_empty", 64'(exp_q.size()), 64'(0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
